// File: rtl/arya_pipe_pkg.sv
// Shared pipeline constants: width defaults, bubble encoding and the fetch FSM state codes.
package arya_pipe_pkg;

  localparam int unsigned DATAPATH_WIDTH_DEF  = 64;
  localparam int unsigned INST_ADDR_WIDTH_DEF = 9;
  localparam logic [63:0] NOP_DEF             = '0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HELD = 2'd2;

endpackage

// File: rtl/fetch_hold_reg.sv
// One-entry buffer that parks the presented fetch entry while the fetch/decode register is stalled.
module fetch_hold_reg #(
  parameter int unsigned DATAPATH_WIDTH  = 64,
  parameter int unsigned INST_ADDR_WIDTH = 9
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_load,
  input  logic                       i_clear,
  input  logic [DATAPATH_WIDTH-1:0]  i_inst,
  input  logic [INST_ADDR_WIDTH-1:0] i_pc,
  output logic                       o_valid,
  output logic [DATAPATH_WIDTH-1:0]  o_inst,
  output logic [INST_ADDR_WIDTH-1:0] o_pc
);

  logic                       r_valid;
  logic [DATAPATH_WIDTH-1:0]  r_inst;
  logic [INST_ADDR_WIDTH-1:0] r_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_inst  <= '0;
      r_pc    <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_inst  <= i_inst;
      r_pc    <= i_pc;
    end
  end

  assign o_valid = r_valid;
  assign o_inst  = r_inst;
  assign o_pc    = r_pc;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: drives a 1-cycle synchronous imem, presents one entry per cycle
// to the fetch/decode register, parks it across stalls and restarts on redirects.
module inst_fetch_unit
  import arya_pipe_pkg::*;
#(
  parameter int unsigned                DATAPATH_WIDTH  = DATAPATH_WIDTH_DEF,
  parameter int unsigned                INST_ADDR_WIDTH = INST_ADDR_WIDTH_DEF,
  parameter logic [DATAPATH_WIDTH-1:0]  NOP             = DATAPATH_WIDTH'(NOP_DEF)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       redirect,
  input  logic [INST_ADDR_WIDTH-1:0] redirect_pc,
  output logic [INST_ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATAPATH_WIDTH-1:0]  imem_data,
  output logic [DATAPATH_WIDTH-1:0]  fetch_inst,
  output logic [INST_ADDR_WIDTH-1:0] fetch_pc,
  output logic                       fetch_valid,
  output logic                       fd_en
);

  logic [1:0]                 r_state;
  logic [INST_ADDR_WIDTH-1:0] r_pc;
  logic                       r_req_valid;
  logic [INST_ADDR_WIDTH-1:0] r_req_pc;

  logic                       w_hold_valid;
  logic [DATAPATH_WIDTH-1:0]  w_hold_inst;
  logic [INST_ADDR_WIDTH-1:0] w_hold_pc;
  logic                       w_hold_load;
  logic                       w_hold_clear;
  logic                       w_pres_valid;
  logic [DATAPATH_WIDTH-1:0]  w_pres_inst;
  logic [INST_ADDR_WIDTH-1:0] w_pres_pc;
  logic                       w_fetch_valid;

  // Park the in-flight read only when it is valid and the consumer cannot take it.
  assign w_hold_load  = !reset && !redirect && (r_state == ST_RUN) && stall && r_req_valid;
  assign w_hold_clear = redirect || ((r_state == ST_HELD) && !stall);

  fetch_hold_reg #(
    .DATAPATH_WIDTH (DATAPATH_WIDTH),
    .INST_ADDR_WIDTH(INST_ADDR_WIDTH)
  ) u_hold (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_hold_load),
    .i_clear(w_hold_clear),
    .i_inst (imem_data),
    .i_pc   (r_req_pc),
    .o_valid(w_hold_valid),
    .o_inst (w_hold_inst),
    .o_pc   (w_hold_pc)
  );

  always_comb begin
    w_pres_valid = r_req_valid;
    w_pres_inst  = imem_data;
    w_pres_pc    = r_req_pc;
    if (r_state == ST_HELD) begin
      w_pres_valid = w_hold_valid;
      w_pres_inst  = w_hold_inst;
      w_pres_pc    = w_hold_pc;
    end
  end

  assign w_fetch_valid = !reset && !redirect && (r_state != ST_IDLE) && w_pres_valid;
  assign fetch_valid   = w_fetch_valid;
  assign fetch_inst    = w_fetch_valid ? w_pres_inst : NOP;
  assign fetch_pc      = w_fetch_valid ? w_pres_pc : '0;
  assign fd_en         = !stall || redirect;
  assign imem_addr     = (redirect && !reset) ? redirect_pc : r_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_pc        <= '0;
      r_req_valid <= 1'b0;
      r_req_pc    <= '0;
    end else if (redirect) begin
      r_state     <= ST_RUN;
      r_pc        <= redirect_pc + 1'b1;
      r_req_valid <= 1'b1;
      r_req_pc    <= redirect_pc;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state     <= ST_RUN;
          r_pc        <= r_pc + 1'b1;
          r_req_valid <= 1'b1;
          r_req_pc    <= r_pc;
        end
        ST_RUN: begin
          if (!stall) begin
            r_pc        <= r_pc + 1'b1;
            r_req_valid <= 1'b1;
            r_req_pc    <= r_pc;
          end else if (r_req_valid) begin
            r_req_valid <= 1'b0;
            r_state     <= ST_HELD;
          end
        end
        ST_HELD: begin
          // r_pc already points past the held entry, so resuming issues it with no bubble.
          if (!stall) begin
            r_state     <= ST_RUN;
            r_pc        <= r_pc + 1'b1;
            r_req_valid <= 1'b1;
            r_req_pc    <= r_pc;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit against a synchronous memory holding word[n] = n + 100.
module tb_inst_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [8:0]  redirect_pc;
  logic [8:0]  imem_addr;
  logic [63:0] imem_data;
  logic [63:0] fetch_inst;
  logic [8:0]  fetch_pc;
  logic        fetch_valid;
  logic        fd_en;

  int errors = 0;
  int checks = 0;

  inst_fetch_unit #(
    .DATAPATH_WIDTH (64),
    .INST_ADDR_WIDTH(9)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .fetch_inst (fetch_inst),
    .fetch_pc   (fetch_pc),
    .fetch_valid(fetch_valid),
    .fd_en      (fd_en)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) imem_data <= 64'(imem_addr) + 64'd100;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected instruction follows from the memory contents: pc + 100 when valid, NOP otherwise.
  task automatic chk_fetch(input string tag, input logic v, input int unsigned pc);
    chk({tag, ".valid"}, 64'(fetch_valid), 64'(v));
    chk({tag, ".pc"},    64'(fetch_pc),    v ? 64'(pc) : 64'd0);
    chk({tag, ".inst"},  fetch_inst,       v ? 64'(pc) + 64'd100 : 64'd0);
  endtask

  task automatic step(input logic rst, input logic stl, input logic rdr, input logic [8:0] rpc);
    @(negedge clk);
    reset       = rst;
    stall       = stl;
    redirect    = rdr;
    redirect_pc = rpc;
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

    step(1, 1, 1, 9'd33);
    chk_fetch("rst0", 0, 0);
    step(1, 1, 1, 9'd33);
    chk_fetch("rst1", 0, 0);

    step(0, 0, 0, 0);
    chk_fetch("idle", 0, 0);
    chk("idle.addr", 64'(imem_addr), 64'd0);
    for (int unsigned p = 0; p < 5; p++) begin
      step(0, 0, 0, 0);
      chk_fetch("seq", 1, p);
      chk("seq.fd_en", 64'(fd_en), 64'd1);
    end

    // Three stalled cycles with pc 5 presented, then release.
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0);
      chk_fetch("stall", 1, 5);
      chk("stall.fd_en", 64'(fd_en), 64'd0);
    end
    step(0, 0, 0, 0);
    chk_fetch("release", 1, 5);
    chk("release.fd_en", 64'(fd_en), 64'd1);
    step(0, 0, 0, 0);
    chk_fetch("after_stall", 1, 6);

    step(0, 0, 1, 9'd40);
    chk_fetch("redir40", 0, 0);
    chk("redir40.fd_en", 64'(fd_en), 64'd1);
    chk("redir40.addr", 64'(imem_addr), 64'd40);
    step(0, 0, 0, 0);
    chk_fetch("tgt40", 1, 40);

    step(0, 1, 0, 0);
    chk_fetch("stall41", 1, 41);
    step(0, 1, 1, 9'd20);
    chk_fetch("held_redir", 0, 0);
    chk("held_redir.fd_en", 64'(fd_en), 64'd1);
    step(0, 0, 0, 0);
    chk_fetch("tgt20", 1, 20);

    step(0, 0, 1, 9'd510);
    chk_fetch("redir510", 0, 0);
    step(0, 0, 0, 0); chk_fetch("wrap510", 1, 510);
    step(0, 0, 0, 0); chk_fetch("wrap511", 1, 511);
    step(0, 0, 0, 0); chk_fetch("wrap0",   1, 0);
    step(0, 0, 0, 0); chk_fetch("wrap1",   1, 1);

    step(0, 0, 1, 9'd511);
    chk_fetch("redir511", 0, 0);
    step(0, 0, 0, 0); chk_fetch("r511", 1, 511);
    step(0, 1, 0, 0); chk_fetch("r511_next", 1, 0);
    step(0, 1, 0, 0); chk_fetch("held0", 1, 0);

    // Reset while HELD must drop the parked entry.
    step(1, 1, 0, 0);
    chk_fetch("rst_held", 0, 0);
    step(0, 0, 0, 0);
    chk_fetch("rst_idle", 0, 0);
    chk("rst_idle.addr", 64'(imem_addr), 64'd0);
    step(0, 0, 0, 0); chk_fetch("restart0", 1, 0);
    step(0, 0, 0, 0); chk_fetch("restart1", 1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
